// File: rtl/gg_pkg.sv
// Shared types and block-order decode for the gg macroblock pipeline.
// Pure combinational helpers; no state.
package gg_pkg;

    typedef logic [2:0] gg_cidx_t;
    typedef logic [3:0] gg_bidx_t;

    localparam gg_cidx_t CIDX_LUMA   = 3'd0;
    localparam gg_cidx_t CIDX_ACLUMA = 3'd1;
    localparam gg_cidx_t CIDX_CB     = 3'd2;
    localparam gg_cidx_t CIDX_CR     = 3'd3;
    localparam gg_cidx_t CIDX_DCCB   = 3'd4;
    localparam gg_cidx_t CIDX_DCCR   = 3'd5;
    localparam gg_cidx_t CIDX_DCY    = 3'd6;

    typedef struct packed {
        gg_cidx_t cidx;
        gg_bidx_t bidx;
        logic     last;
    } gg_blk_t;

    // Maps the running block index of an MB onto (cidx, bidx) and flags the final block.
    function automatic gg_blk_t gg_decode(input logic [4:0] idx, input logic intra16,
                                          input logic chroma_en);
        gg_blk_t    b;
        logic [4:0] luma_n;
        logic [4:0] total;
        logic [4:0] off;
        luma_n = intra16 ? 5'd17 : 5'd16;
        total  = chroma_en ? luma_n + 5'd10 : luma_n;
        off    = idx - luma_n;
        b.cidx = CIDX_LUMA;
        b.bidx = '0;
        if (idx < luma_n) begin
            if (intra16 && idx == 5'd0) begin
                b.cidx = CIDX_DCY;
            end else if (intra16) begin
                b.cidx = CIDX_ACLUMA;
                b.bidx = 4'(idx - 5'd1);
            end else begin
                b.bidx = idx[3:0];
            end
        end else if (off == 5'd0) begin
            b.cidx = CIDX_DCCB;
        end else if (off == 5'd1) begin
            b.cidx = CIDX_DCCR;
        end else if (off < 5'd6) begin
            b.cidx = CIDX_CB;
            b.bidx = 4'(off - 5'd2);
        end else begin
            b.cidx = CIDX_CR;
            b.bidx = 4'(off - 5'd6);
        end
        b.last = (idx == total - 5'd1);
        return b;
    endfunction

endpackage

// File: rtl/gg_mb_pos_counter.sv
// Macroblock raster position counter with clear, advance and frame-wrap pulse.
// Latency: position updates on the edge after advance/clear; wrap is combinational with advance.
// Backpressure: none, advance is a single-cycle event from the sequencer.
module gg_mb_pos_counter #(
    parameter int MB_COLS = 22,
    parameter int MB_ROWS = 18
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       advance,
    output logic [7:0] mb_x,
    output logic [7:0] mb_y,
    output logic       wrap
);

    if (MB_COLS < 1 || MB_COLS > 256 || MB_ROWS < 1 || MB_ROWS > 256) begin : g_bad_dims
        $error("gg_mb_pos_counter: MB_COLS/MB_ROWS must be within 1..256");
    end

    localparam logic [7:0] X_LAST = 8'(MB_COLS - 1);
    localparam logic [7:0] Y_LAST = 8'(MB_ROWS - 1);

    logic at_x_end;

    assign at_x_end = (mb_x == X_LAST);
    assign wrap     = advance && at_x_end && (mb_y == Y_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mb_x <= '0;
            mb_y <= '0;
        end else if (clear) begin
            mb_x <= '0;
            mb_y <= '0;
        end else if (advance) begin
            if (at_x_end) begin
                mb_x <= '0;
                mb_y <= wrap ? 8'd0 : mb_y + 8'd1;
            end else begin
                mb_x <= mb_x + 8'd1;
            end
        end
    end

endmodule

// File: rtl/gg_mb_sequencer.sv
// Issues the 4x4 block order of one macroblock into gg_process and tracks MB position.
// Latency: first block the cycle after start; mb_done PIPE_LAT cycles after last accept.
// Backpressure: blk_valid/blk_ready; presented block and flags hold while blk_ready=0.
module gg_mb_sequencer
    import gg_pkg::*;
#(
    parameter int MB_COLS   = 22,
    parameter int MB_ROWS   = 18,
    parameter int PIPE_LAT  = 4,
    parameter int CHROMA_EN = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       start,
    input  logic       intra16,
    input  logic       blk_ready,
    output logic       blk_valid,
    output logic [2:0] cidx,
    output logic [3:0] bidx,
    output logic       abv_out_of_pic,
    output logic       left_out_of_pic,
    output logic [7:0] mb_x,
    output logic [7:0] mb_y,
    output logic       busy,
    output logic       mb_done,
    output logic       frame_done
);

    localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t           state, state_nxt;
    logic [4:0]       blk_idx, blk_idx_nxt;
    logic             intra16_q, intra16_nxt;
    logic [CNT_W-1:0] drain_cnt, drain_cnt_nxt;
    logic             pos_clear;
    gg_blk_t          cur;

    assign cur = gg_decode(blk_idx, intra16_q, CHROMA_EN != 0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            blk_idx   <= '0;
            intra16_q <= 1'b0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            blk_idx   <= blk_idx_nxt;
            intra16_q <= intra16_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        blk_idx_nxt   = blk_idx;
        intra16_nxt   = intra16_q;
        drain_cnt_nxt = drain_cnt;
        blk_valid     = 1'b0;
        mb_done       = 1'b0;
        pos_clear     = 1'b0;
        case (state)
            S_IDLE: begin
                // A simultaneous frame_start clears the position on the same edge the MB starts.
                pos_clear = frame_start;
                if (start) begin
                    state_nxt   = S_ISSUE;
                    blk_idx_nxt = '0;
                    intra16_nxt = intra16;
                end
            end
            S_ISSUE: begin
                blk_valid = 1'b1;
                if (blk_ready) begin
                    if (cur.last) begin
                        state_nxt     = S_DRAIN;
                        drain_cnt_nxt = DRAIN_LOAD;
                    end else begin
                        blk_idx_nxt = blk_idx + 5'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) begin
                    mb_done   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    drain_cnt_nxt = drain_cnt - 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy            = (state != S_IDLE);
    assign cidx            = blk_valid ? cur.cidx : 3'd0;
    assign bidx            = blk_valid ? cur.bidx : 4'd0;
    assign abv_out_of_pic  = (mb_y == 8'd0);
    assign left_out_of_pic = (mb_x == 8'd0);

    gg_mb_pos_counter #(
        .MB_COLS(MB_COLS),
        .MB_ROWS(MB_ROWS)
    ) u_pos (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (pos_clear),
        .advance (mb_done),
        .mb_x    (mb_x),
        .mb_y    (mb_y),
        .wrap    (frame_done)
    );

endmodule

// File: tb/tb_gg_mb_sequencer.sv
// Bench for gg_mb_sequencer: a chroma build and a monochrome build on a 2x2 picture,
// each compared every cycle against a queue-based model of the block order and MB timing.
module tb_gg_mb_sequencer;

    localparam int LAT  = 4;
    localparam int COLS = 2;
    localparam int ROWS = 2;

    typedef struct {
        int c;
        int b;
    } blk_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       intra16 = 1'b0;
    logic       blk_ready = 1'b0;
    logic       start_w[2];
    logic       frame_start_w[2];
    logic       blk_valid_w[2];
    logic [2:0] cidx_w[2];
    logic [3:0] bidx_w[2];
    logic       abv_w[2];
    logic       left_w[2];
    logic [7:0] mb_x_w[2];
    logic [7:0] mb_y_w[2];
    logic       busy_w[2];
    logic       mb_done_w[2];
    logic       frame_done_w[2];

    always #5 clk = ~clk;

    gg_mb_sequencer #(.MB_COLS(COLS), .MB_ROWS(ROWS), .PIPE_LAT(LAT), .CHROMA_EN(1)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start_w[0]), .start(start_w[0]),
        .intra16(intra16), .blk_ready(blk_ready), .blk_valid(blk_valid_w[0]),
        .cidx(cidx_w[0]), .bidx(bidx_w[0]), .abv_out_of_pic(abv_w[0]),
        .left_out_of_pic(left_w[0]), .mb_x(mb_x_w[0]), .mb_y(mb_y_w[0]), .busy(busy_w[0]),
        .mb_done(mb_done_w[0]), .frame_done(frame_done_w[0]));

    gg_mb_sequencer #(.MB_COLS(COLS), .MB_ROWS(ROWS), .PIPE_LAT(LAT), .CHROMA_EN(0)) u_dut_m (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start_w[1]), .start(start_w[1]),
        .intra16(intra16), .blk_ready(blk_ready), .blk_valid(blk_valid_w[1]),
        .cidx(cidx_w[1]), .bidx(bidx_w[1]), .abv_out_of_pic(abv_w[1]),
        .left_out_of_pic(left_w[1]), .mb_x(mb_x_w[1]), .mb_y(mb_y_w[1]), .busy(busy_w[1]),
        .mb_done(mb_done_w[1]), .frame_done(frame_done_w[1]));

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model state per build: pending block queue, busy, last-accept cycle, position.
    blk_t m_q[2][$];
    bit   m_busy[2];
    int   m_last[2];
    int   m_x[2];
    int   m_y[2];

    // Observed statistics, pinned against hand-computed literals.
    int   acc[2];
    int   last_acc[2];
    int   lat[2];
    int   done_cnt[2];
    int   fd_cnt[2];
    int   bad_chroma;
    logic prev_busy0;
    logic [1:0] flag_q[$];

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h expected=%0h", nm, d, cyc, act, exp);
        end
    endtask

    function automatic void push(input int d, input int c, input int b);
        blk_t e;
        e.c = c;
        e.b = b;
        m_q[d].push_back(e);
    endfunction

    function automatic void build(input int d, input logic i16);
        if (i16) begin
            push(d, 6, 0);
            for (int i = 0; i < 16; i++) push(d, 1, i);
        end else begin
            for (int i = 0; i < 16; i++) push(d, 0, i);
        end
        if (d == 0) begin
            push(d, 4, 0);
            push(d, 5, 0);
            for (int i = 0; i < 4; i++) push(d, 2, i);
            for (int i = 0; i < 4; i++) push(d, 3, i);
        end
    endfunction

    task automatic compare(input int d);
        logic exp_valid;
        logic exp_done;
        exp_valid = (m_q[d].size() > 0);
        exp_done  = m_busy[d] && !exp_valid && (m_last[d] >= 0) && (cyc == m_last[d] + LAT);
        check("blk_valid", d, blk_valid_w[d], exp_valid);
        if (exp_valid) begin
            check("cidx", d, cidx_w[d], m_q[d][0].c);
            check("bidx", d, bidx_w[d], m_q[d][0].b);
        end
        check("busy", d, busy_w[d], m_busy[d]);
        check("mb_done", d, mb_done_w[d], exp_done);
        check("frame_done", d, frame_done_w[d],
              exp_done && (m_x[d] == COLS - 1) && (m_y[d] == ROWS - 1));
        check("mb_x", d, mb_x_w[d], m_x[d]);
        check("mb_y", d, mb_y_w[d], m_y[d]);
        check("abv_out_of_pic", d, abv_w[d], m_y[d] == 0);
        check("left_out_of_pic", d, left_w[d], m_x[d] == 0);
    endtask

    function automatic void observe(input int d, input logic rdy);
        if (blk_valid_w[d] && rdy) begin
            acc[d]++;
            last_acc[d] = cyc;
        end
        if (mb_done_w[d]) begin
            lat[d] = cyc - last_acc[d];
            done_cnt[d]++;
        end
        if (frame_done_w[d]) fd_cnt[d]++;
        if (d == 1 && blk_valid_w[1] && cidx_w[1] >= 3'd2 && cidx_w[1] <= 3'd5) bad_chroma++;
        if (d == 0) begin
            if (busy_w[0] && !prev_busy0) flag_q.push_back({abv_w[0], left_w[0]});
            prev_busy0 = busy_w[0];
        end
    endfunction

    function automatic void update(input int d, input logic st, input logic fs);
        if (!reset_n) begin
            m_q[d].delete();
            m_busy[d] = 1'b0;
            m_last[d] = -1;
            m_x[d] = 0;
            m_y[d] = 0;
        end else if (!m_busy[d]) begin
            if (fs) begin
                m_x[d] = 0;
                m_y[d] = 0;
            end
            if (st) begin
                m_busy[d] = 1'b1;
                m_last[d] = -1;
                build(d, intra16);
            end
        end else if (m_q[d].size() > 0) begin
            if (blk_ready) begin
                void'(m_q[d].pop_front());
                if (m_q[d].size() == 0) m_last[d] = cyc;
            end
        end else if (cyc == m_last[d] + LAT) begin
            m_busy[d] = 1'b0;
            m_x[d]++;
            if (m_x[d] == COLS) begin
                m_x[d] = 0;
                m_y[d]++;
                if (m_y[d] == ROWS) m_y[d] = 0;
            end
        end
    endfunction

    // One clock cycle: check outputs, drive this cycle's inputs, advance the model across the edge.
    task automatic step(input logic rn, input logic [1:0] st, input logic i16, input logic rdy,
                        input logic [1:0] fs);
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            compare(d);
            observe(d, rdy);
        end
        reset_n = rn;
        start_w[0] = st[0];
        start_w[1] = st[1];
        frame_start_w[0] = fs[0];
        frame_start_w[1] = fs[1];
        intra16 = i16;
        blk_ready = rdy;
        for (int d = 0; d < 2; d++) update(d, st[d], fs[d]);
    endtask

    // rdy_mode 0: always ready; 1: ready toggles 0/1. hold: keep start/frame_start high while busy.
    task automatic run_mb(input logic i16, input int rdy_mode, input logic hold, input logic fs_first);
        logic rdy;
        acc[0] = 0;
        acc[1] = 0;
        step(1'b1, 2'b11, i16, 1'b1, fs_first ? 2'b11 : 2'b00);
        for (int n = 0; n < 200 && (m_busy[0] || m_busy[1]); n++) begin
            rdy = (rdy_mode == 1) ? n[0] : 1'b1;
            step(1'b1, hold ? {m_busy[1], m_busy[0]} : 2'b00, i16 ^ n[0], rdy,
                 hold ? {m_busy[1], m_busy[0]} : 2'b00);
        end
        check("mb_timeout", 0, m_busy[0] | m_busy[1], 0);
        step(1'b1, 2'b00, 1'b0, 1'b1, 2'b00);
    endtask

    initial begin
        start_w[0] = 1'b0;
        start_w[1] = 1'b0;
        frame_start_w[0] = 1'b0;
        frame_start_w[1] = 1'b0;
        prev_busy0 = 1'b0;
        bad_chroma = 0;
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0;
            m_last[d] = -1;
            m_x[d] = 0;
            m_y[d] = 0;
            acc[d] = 0;
            last_acc[d] = 0;
            lat[d] = 0;
            done_cnt[d] = 0;
            fd_cnt[d] = 0;
        end

        // Reset state, then release.
        step(1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
        step(1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
        check("rst_abv", 0, abv_w[0], 1);
        check("rst_left", 0, left_w[0], 1);
        check("rst_busy", 0, busy_w[0], 0);
        step(1'b1, 2'b00, 1'b0, 1'b1, 2'b00);
        step(1'b1, 2'b00, 1'b0, 1'b1, 2'b00);

        // MB (0,0): full luma, always ready.
        run_mb(1'b0, 0, 1'b0, 1'b1);
        check("lit_blocks_chroma", 0, acc[0], 26);
        check("lit_blocks_mono", 1, acc[1], 16);
        check("lit_done_latency", 0, lat[0], 4);
        check("lit_done_latency", 1, lat[1], 4);

        // MB (1,0): intra16 order, intra16 toggled while busy.
        run_mb(1'b1, 0, 1'b0, 1'b0);
        check("lit_blocks_i16_chroma", 0, acc[0], 27);
        check("lit_blocks_i16_mono", 1, acc[1], 17);
        check("lit_mono_no_chroma", 1, bad_chroma, 0);

        // MB (0,1): ready toggling each cycle.
        run_mb(1'b0, 1, 1'b0, 1'b0);
        check("lit_blocks_toggle", 0, acc[0], 26);
        check("lit_latency_toggle", 0, lat[0], 4);

        // MB (1,1): last MB of the 2x2 picture.
        run_mb(1'b1, 0, 1'b0, 1'b0);
        check("lit_frame_done", 0, fd_cnt[0], 1);
        check("lit_frame_done", 1, fd_cnt[1], 1);
        check("lit_wrap_x", 0, mb_x_w[0], 0);
        check("lit_wrap_y", 0, mb_y_w[0], 0);
        check("lit_flags_mb0", 0, flag_q[0], 2'b11);
        check("lit_flags_mb1", 0, flag_q[1], 2'b10);
        check("lit_flags_mb2", 0, flag_q[2], 2'b01);
        check("lit_flags_mb3", 0, flag_q[3], 2'b00);

        // MB (0,0) with start and frame_start held through busy and the mb_done cycle.
        run_mb(1'b0, 0, 1'b1, 1'b0);
        check("lit_done_count", 0, done_cnt[0], 5);
        check("lit_pos_after_hold", 0, mb_x_w[0], 1);

        // MB (1,0) aborted by reset while block 10 is presented.
        acc[0] = 0;
        acc[1] = 0;
        step(1'b1, 2'b11, 1'b0, 1'b1, 2'b00);
        for (int n = 0; n < 100 && acc[0] < 10; n++) step(1'b1, 2'b00, 1'b0, 1'b1, 2'b00);
        check("lit_reached_blk10", 0, acc[0], 10);
        step(1'b0, 2'b00, 1'b0, 1'b1, 2'b00);
        step(1'b0, 2'b00, 1'b0, 1'b1, 2'b00);
        check("lit_abort_busy", 0, busy_w[0], 0);
        check("lit_abort_valid", 0, blk_valid_w[0], 0);
        check("lit_abort_x", 0, mb_x_w[0], 0);
        step(1'b1, 2'b00, 1'b0, 1'b1, 2'b00);
        for (int n = 0; n < 8; n++) step(1'b1, 2'b00, 1'b0, 1'b1, 2'b00);
        check("lit_no_done_after_abort", 0, done_cnt[0], 5);

        // Fresh MB with frame_start and start together.
        run_mb(1'b0, 0, 1'b0, 1'b1);
        check("lit_blocks_after_abort", 0, acc[0], 26);
        check("lit_done_after_abort", 0, done_cnt[0], 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
